// File: rtl/marc_control_unit.sv
// marc_control_unit
//   Multi-cycle control unit for the MARC 16-bit processor. It fetches an
//   instruction word into an internal IR, decodes it, and sequences the
//   datapath through FETCH -> DECODE -> EXEC -> [MEM] -> [WB].
//
// Ports
//   clk              rising-edge system clock
//   reset            asynchronous, active-low; forces FETCH, clears IR and all strobes
//   dataIn[15:0]     instruction word from memory, captured in FETCH when mem_ready=1
//   mem_ready        memory completes the current access this cycle
//   z_flag, n_flag   ALU zero / negative flags, sampled in EXEC for branches
//   mem_req, rw      memory request and direction (1=write); addr_sel 0=PC, 1=busA
//   pc_inc, pc_load  PC increment pulse in FETCH / PC<=PC+imm for a taken branch
//   rf_we, rf_waddr  register-file write strobe and destination (WB only)
//   rf_raddr_a/b     register-file read ports, held DECODE through WB
//   imm[15:0]        immediate for setlow/sethi (zero-extended) and branches (sign-extended)
//   alu_op[2:0]      ALU operation, held DECODE through WB
//   wb_sel           write-back source, 0=ALU, 1=dataIn (loads)
//   state[2:0]       current FSM state; halt sticky halt flag; illegal one-cycle pulse
module marc_control_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] dataIn,
    input  logic        mem_ready,
    input  logic        z_flag,
    input  logic        n_flag,
    output logic        mem_req,
    output logic        rw,
    output logic        addr_sel,
    output logic        pc_inc,
    output logic        pc_load,
    output logic        rf_we,
    output logic [2:0]  rf_waddr,
    output logic [2:0]  rf_raddr_a,
    output logic [2:0]  rf_raddr_b,
    output logic [15:0] imm,
    output logic [2:0]  alu_op,
    output logic        wb_sel,
    output logic [2:0]  state,
    output logic        halt,
    output logic        illegal
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5
    } stateT;

    localparam logic [4:0] OP_ADD    = 5'b00000;
    localparam logic [4:0] OP_SUB    = 5'b00001;
    localparam logic [4:0] OP_AND    = 5'b00010;
    localparam logic [4:0] OP_OR     = 5'b00011;
    localparam logic [4:0] OP_SETLOW = 5'b01010;
    localparam logic [4:0] OP_SETHI  = 5'b01011;
    localparam logic [4:0] OP_LD     = 5'b10000;
    localparam logic [4:0] OP_ST     = 5'b10001;
    localparam logic [4:0] OP_BE     = 5'b11000;
    localparam logic [4:0] OP_BNEG   = 5'b11001;
    localparam logic [4:0] OP_HALT   = 5'b11111;

    localparam logic [2:0] ALU_ADD    = 3'b000;
    localparam logic [2:0] ALU_SUB    = 3'b001;
    localparam logic [2:0] ALU_AND    = 3'b010;
    localparam logic [2:0] ALU_OR     = 3'b011;
    localparam logic [2:0] ALU_SETLOW = 3'b100;
    localparam logic [2:0] ALU_SETHI  = 3'b101;
    localparam logic [2:0] ALU_PASSA  = 3'b110;

    // Branch offsets are two's-complement bytes widened to the PC width.
    function automatic logic [15:0] signExtend8(input logic signed [7:0] value);
        return {{8{value[7]}}, value};
    endfunction

    stateT       curState;
    stateT       nxtState;
    logic [15:0] instrReg;
    logic        loadIr;

    logic [4:0]  opcode;
    logic [2:0]  rdField;
    logic [2:0]  rs1Field;
    logic [2:0]  rs2Field;
    logic [7:0]  imm8Field;

    assign opcode    = instrReg[15:11];
    assign rdField   = instrReg[10:8];
    assign rs1Field  = instrReg[7:5];
    assign rs2Field  = instrReg[4:2];
    assign imm8Field = instrReg[7:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            curState <= FETCH;
            instrReg <= 16'h0000;
        end else begin
            curState <= nxtState;
            if (loadIr) begin
                instrReg <= dataIn;
            end
        end
    end

    assign state = curState;

    // Instruction classification and the per-instruction ALU/immediate values.
    logic        isAluOp;
    logic        isSetOp;
    logic        isLoad;
    logic        isStore;
    logic        isBe;
    logic        isBneg;
    logic        isHaltOp;
    logic        isSetHi;
    logic        isLegal;
    logic [2:0]  decAluOp;
    logic [15:0] decImm;

    always_comb begin
        isAluOp  = 1'b0;
        isSetOp  = 1'b0;
        isLoad   = 1'b0;
        isStore  = 1'b0;
        isBe     = 1'b0;
        isBneg   = 1'b0;
        isHaltOp = 1'b0;
        isSetHi  = 1'b0;
        decAluOp = ALU_ADD;
        decImm   = 16'h0000;
        case (opcode)
            OP_ADD:    begin isAluOp = 1'b1; decAluOp = ALU_ADD; end
            OP_SUB:    begin isAluOp = 1'b1; decAluOp = ALU_SUB; end
            OP_AND:    begin isAluOp = 1'b1; decAluOp = ALU_AND; end
            OP_OR:     begin isAluOp = 1'b1; decAluOp = ALU_OR;  end
            OP_SETLOW: begin
                isSetOp  = 1'b1;
                decAluOp = ALU_SETLOW;
                decImm   = {8'h00, imm8Field};
            end
            OP_SETHI:  begin
                isSetOp  = 1'b1;
                isSetHi  = 1'b1;
                decAluOp = ALU_SETHI;
                decImm   = {8'h00, imm8Field};
            end
            // Memory ops pass busA (rs1) straight through as the address.
            OP_LD:     begin isLoad  = 1'b1; decAluOp = ALU_PASSA; end
            OP_ST:     begin isStore = 1'b1; decAluOp = ALU_PASSA; end
            OP_BE:     begin isBe    = 1'b1; decImm = signExtend8(imm8Field); end
            OP_BNEG:   begin isBneg  = 1'b1; decImm = signExtend8(imm8Field); end
            OP_HALT:   begin isHaltOp = 1'b1; end
            default:   ;
        endcase
        isLegal = isAluOp | isSetOp | isLoad | isStore | isBe | isBneg | isHaltOp;
    end

    // Next-state and strobes. Every output is held at 0 while reset is low so
    // an abort (e.g. mid-MEM) drops mem_req/rw in the same cycle.
    always_comb begin
        nxtState   = curState;
        loadIr     = 1'b0;
        mem_req    = 1'b0;
        rw         = 1'b0;
        addr_sel   = 1'b0;
        pc_inc     = 1'b0;
        pc_load    = 1'b0;
        rf_we      = 1'b0;
        rf_waddr   = 3'd0;
        rf_raddr_a = 3'd0;
        rf_raddr_b = 3'd0;
        imm        = 16'h0000;
        alu_op     = 3'd0;
        wb_sel     = 1'b0;
        halt       = 1'b0;
        illegal    = 1'b0;

        if (reset) begin
            // Decoded operands stay stable from DECODE until the instruction retires.
            if (curState inside {DECODE, EXEC, MEM, WB}) begin
                rf_raddr_a = isSetHi ? rdField : rs1Field;
                rf_raddr_b = rs2Field;
                imm        = decImm;
                alu_op     = decAluOp;
            end

            case (curState)
                FETCH: begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        loadIr   = 1'b1;
                        pc_inc   = 1'b1;
                        nxtState = DECODE;
                    end
                end
                DECODE: begin
                    if (isLegal) begin
                        nxtState = EXEC;
                    end else begin
                        illegal  = 1'b1;
                        nxtState = FETCH;
                    end
                end
                EXEC: begin
                    if (isAluOp || isSetOp) begin
                        nxtState = WB;
                    end else if (isLoad || isStore) begin
                        nxtState = MEM;
                    end else if (isBe || isBneg) begin
                        pc_load  = (isBe & z_flag) | (isBneg & n_flag);
                        nxtState = FETCH;
                    end else begin
                        nxtState = HALT;
                    end
                end
                MEM: begin
                    mem_req  = 1'b1;
                    addr_sel = 1'b1;
                    rw       = isStore;
                    if (mem_ready) begin
                        nxtState = isStore ? FETCH : WB;
                    end
                end
                WB: begin
                    rf_we    = 1'b1;
                    rf_waddr = rdField;
                    wb_sel   = isLoad;
                    nxtState = FETCH;
                end
                HALT: begin
                    halt = 1'b1;
                end
                default: begin
                    nxtState = FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_marc_control_unit.sv
// Scoreboard bench for marc_control_unit: each scenario queues per-cycle
// stimulus and the expected observable outputs, then the queues are drained
// one clock at a time and compared at the falling edge.
module tb_marc_control_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] dataIn;
    logic        mem_ready;
    logic        z_flag;
    logic        n_flag;
    logic        mem_req;
    logic        rw;
    logic        addr_sel;
    logic        pc_inc;
    logic        pc_load;
    logic        rf_we;
    logic [2:0]  rf_waddr;
    logic [2:0]  rf_raddr_a;
    logic [2:0]  rf_raddr_b;
    logic [15:0] imm;
    logic [2:0]  alu_op;
    logic        wb_sel;
    logic [2:0]  state;
    logic        halt;
    logic        illegal;

    marc_control_unit dut (
        .clk        (clk),
        .reset      (reset),
        .dataIn     (dataIn),
        .mem_ready  (mem_ready),
        .z_flag     (z_flag),
        .n_flag     (n_flag),
        .mem_req    (mem_req),
        .rw         (rw),
        .addr_sel   (addr_sel),
        .pc_inc     (pc_inc),
        .pc_load    (pc_load),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_raddr_a (rf_raddr_a),
        .rf_raddr_b (rf_raddr_b),
        .imm        (imm),
        .alu_op     (alu_op),
        .wb_sel     (wb_sel),
        .state      (state),
        .halt       (halt),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  st;
        logic        memReq;
        logic        rw;
        logic        addrSel;
        logic        pcInc;
        logic        pcLoad;
        logic        rfWe;
        logic [2:0]  waddr;
        logic [2:0]  ra;
        logic [2:0]  rb;
        logic [15:0] imm;
        logic [2:0]  aluOp;
        logic        wbSel;
        logic        halt;
        logic        illegal;
    } obsT;

    typedef struct packed {
        logic        ready;
        logic [15:0] data;
        logic        z;
        logic        n;
    } stimT;

    obsT   expQ[$];
    stimT  stimQ[$];
    string tagQ[$];

    int testsRun = 0;
    int testsFailed = 0;

    function automatic obsT sampleDut();
        obsT o;
        o.st      = state;
        o.memReq  = mem_req;
        o.rw      = rw;
        o.addrSel = addr_sel;
        o.pcInc   = pc_inc;
        o.pcLoad  = pc_load;
        o.rfWe    = rf_we;
        o.waddr   = rf_waddr;
        o.ra      = rf_raddr_a;
        o.rb      = rf_raddr_b;
        o.imm     = imm;
        o.aluOp   = alu_op;
        o.wbSel   = wb_sel;
        o.halt    = halt;
        o.illegal = illegal;
        return o;
    endfunction

    task automatic pushCycle(input string tag, input stimT s, input obsT e);
        stimQ.push_back(s);
        expQ.push_back(e);
        tagQ.push_back(tag);
    endtask

    function automatic stimT mkStim(input logic ready, input logic [15:0] data,
                                    input logic z, input logic n);
        stimT s;
        s.ready = ready;
        s.data  = data;
        s.z     = z;
        s.n     = n;
        return s;
    endfunction

    // Expected trace of one instruction, starting in FETCH.
    task automatic queueInstr(input string tag, input logic [15:0] word,
                              input logic z, input logic n,
                              input int fetchWaits, input int memWaits,
                              input int haltCycles);
        logic [4:0] op;
        logic [2:0] rd;
        logic       legal;
        logic       toWb;
        logic       toMem;
        logic       ld;
        logic       st;
        logic       branch;
        logic       taken;
        logic       stop;
        obsT        base;
        obsT        e;
        op     = word[15:11];
        rd     = word[10:8];
        legal  = 1'b1;
        toWb   = 1'b0;
        toMem  = 1'b0;
        ld     = 1'b0;
        st     = 1'b0;
        branch = 1'b0;
        taken  = 1'b0;
        stop   = 1'b0;
        base       = '0;
        base.ra    = word[7:5];
        base.rb    = word[4:2];
        case (op)
            5'b00000: begin toWb = 1'b1; base.aluOp = 3'b000; end
            5'b00001: begin toWb = 1'b1; base.aluOp = 3'b001; end
            5'b00010: begin toWb = 1'b1; base.aluOp = 3'b010; end
            5'b00011: begin toWb = 1'b1; base.aluOp = 3'b011; end
            5'b01010: begin toWb = 1'b1; base.aluOp = 3'b100; base.imm = 16'(word[7:0]); end
            5'b01011: begin
                toWb = 1'b1; base.aluOp = 3'b101; base.imm = 16'(word[7:0]); base.ra = rd;
            end
            5'b10000: begin toMem = 1'b1; ld = 1'b1; toWb = 1'b1; base.aluOp = 3'b110; end
            5'b10001: begin toMem = 1'b1; st = 1'b1; base.aluOp = 3'b110; end
            5'b11000: begin
                branch = 1'b1; taken = z;
                base.imm = word[7] ? (16'hFF00 | 16'(word[7:0])) : 16'(word[7:0]);
            end
            5'b11001: begin
                branch = 1'b1; taken = n;
                base.imm = word[7] ? (16'hFF00 | 16'(word[7:0])) : 16'(word[7:0]);
            end
            5'b11111: stop = 1'b1;
            default:  legal = 1'b0;
        endcase

        for (int k = 0; k < fetchWaits; k++) begin
            e = '0; e.memReq = 1'b1;
            pushCycle({tag, ".fetchWait"}, mkStim(1'b0, 16'($urandom), z, n), e);
        end
        e = '0; e.memReq = 1'b1; e.pcInc = 1'b1;
        pushCycle({tag, ".fetch"}, mkStim(1'b1, word, z, n), e);

        // mem_ready held high outside FETCH/MEM must have no effect.
        e = base; e.st = 3'd1; e.illegal = !legal;
        pushCycle({tag, ".decode"}, mkStim(1'b1, 16'hFFFF, z, n), e);
        if (!legal) return;

        e = base; e.st = 3'd2; e.pcLoad = branch & taken;
        pushCycle({tag, ".exec"}, mkStim(1'b1, 16'hFFFF, z, n), e);
        if (branch) return;

        if (stop) begin
            for (int k = 0; k < haltCycles; k++) begin
                e = '0; e.st = 3'd5; e.halt = 1'b1;
                pushCycle({tag, ".halt"}, mkStim(1'($urandom), 16'($urandom), z, n), e);
            end
            return;
        end

        if (toMem) begin
            for (int k = 0; k <= memWaits; k++) begin
                e = base; e.st = 3'd3; e.memReq = 1'b1; e.addrSel = 1'b1; e.rw = st;
                pushCycle({tag, ".mem"}, mkStim(k == memWaits, 16'($urandom), z, n), e);
            end
        end

        if (toWb) begin
            e = base; e.st = 3'd4; e.rfWe = 1'b1; e.waddr = rd; e.wbSel = ld;
            pushCycle({tag, ".wb"}, mkStim(1'b1, 16'hFFFF, z, n), e);
        end
    endtask

    // Entered and left at posedge+1; compares at the falling edge.
    task automatic drain(input int maxCycles);
        stimT  s;
        obsT   e;
        obsT   got;
        string t;
        int    n;
        n = 0;
        while (expQ.size() > 0 && n < maxCycles) begin
            s = stimQ.pop_front();
            e = expQ.pop_front();
            t = tagQ.pop_front();
            mem_ready = s.ready;
            dataIn    = s.data;
            z_flag    = s.z;
            n_flag    = s.n;
            @(negedge clk);
            got = sampleDut();
            testsRun++;
            if (got !== e) begin
                testsFailed++;
                $display("FAIL %s: got %h expected %h", t, got, e);
            end
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic clearQueues();
        expQ.delete();
        stimQ.delete();
        tagQ.delete();
    endtask

    task automatic test_reset();
        obsT got;
        obsT e;
        reset = 1'b0; mem_ready = 1'b1; dataIn = 16'h5140; z_flag = 1'b1; n_flag = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        got = sampleDut();
        testsRun++;
        if (got !== obsT'(0)) begin
            testsFailed++;
            $display("FAIL reset.outputsZero: got %h expected %h", got, obsT'(0));
        end
        reset = 1'b1; mem_ready = 1'b0;
        @(negedge clk);
        got = sampleDut();
        e = '0; e.memReq = 1'b1;
        testsRun++;
        if (got !== e) begin
            testsFailed++;
            $display("FAIL reset.firstFetch: got %h expected %h", got, e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_setlow();
        queueInstr("setlow", 16'h5140, 1'b0, 1'b0, 1, 0, 0);
        drain(100);
    endtask

    task automatic test_sethi();
        queueInstr("sethi", 16'h5A01, 1'b0, 1'b0, 0, 0, 0);
        drain(100);
    endtask

    task automatic test_alu();
        logic [15:0] w;
        for (int i = 0; i < 6; i++) begin
            w = {3'b000, 2'($urandom), 11'($urandom)};
            queueInstr($sformatf("alu%0d", i), w, 1'($urandom), 1'($urandom), i % 2, 0, 0);
        end
        queueInstr("addRd0", 16'h00E8, 1'b0, 1'b0, 0, 0, 0);
        drain(200);
    endtask

    task automatic test_load_wait();
        queueInstr("ldWait", 16'h8360, 1'b0, 1'b0, 0, 3, 0);
        queueInstr("ldNoWait", 16'h8640, 1'b0, 1'b0, 0, 0, 0);
        drain(100);
    endtask

    task automatic test_store();
        queueInstr("st", 16'h88A4, 1'b1, 1'b1, 0, 0, 0);
        queueInstr("stWait", 16'h8FFC, 1'b0, 1'b0, 2, 2, 0);
        drain(100);
    endtask

    task automatic test_branch();
        queueInstr("beTaken", 16'hC0FE, 1'b1, 1'b0, 0, 0, 0);
        queueInstr("beNotTaken", 16'hC0FE, 1'b0, 1'b1, 0, 0, 0);
        queueInstr("bnegTaken", 16'hC805, 1'b0, 1'b1, 0, 0, 0);
        queueInstr("bnegNotTaken", 16'hC880, 1'b1, 1'b0, 0, 0, 0);
        drain(100);
    endtask

    task automatic test_illegal();
        queueInstr("illegal", 16'h3800, 1'b0, 1'b0, 0, 0, 0);
        queueInstr("illegalB", 16'h6ABC, 1'b0, 1'b0, 0, 0, 0);
        queueInstr("afterIllegal", 16'h0144, 1'b0, 1'b0, 0, 0, 0);
        drain(100);
    endtask

    task automatic test_back_to_back();
        queueInstr("b2bSetlow", 16'h57FF, 1'b0, 1'b0, 0, 0, 0);
        queueInstr("b2bLd", 16'h8120, 1'b0, 1'b0, 0, 1, 0);
        queueInstr("b2bBe", 16'hC07F, 1'b1, 1'b0, 0, 0, 0);
        queueInstr("b2bSt", 16'h8B1C, 1'b0, 1'b0, 0, 0, 0);
        queueInstr("b2bOr", 16'h1F7C, 1'b0, 1'b0, 0, 0, 0);
        drain(200);
    endtask

    task automatic test_reset_mid_mem();
        obsT got;
        obsT e;
        queueInstr("ldAbort", 16'h8360, 1'b0, 1'b0, 0, 10, 0);
        drain(4);
        clearQueues();
        #2;
        reset = 1'b0;
        #1;
        got = sampleDut();
        testsRun++;
        if (got !== obsT'(0)) begin
            testsFailed++;
            $display("FAIL abortMem.outputsZero: got %h expected %h", got, obsT'(0));
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            e = '0; e.memReq = 1'b1;
            pushCycle("abortMem.fetchNoWb", mkStim(1'b0, 16'h0000, 1'b0, 1'b0), e);
        end
        queueInstr("afterAbort", 16'h0A48, 1'b0, 1'b0, 0, 0, 0);
        drain(100);
    endtask

    task automatic test_halt();
        obsT got;
        obsT e;
        queueInstr("halt", 16'hF800, 1'b0, 1'b0, 0, 0, 12);
        drain(100);
        #2;
        reset = 1'b0;
        #1;
        got = sampleDut();
        testsRun++;
        if (got !== obsT'(0)) begin
            testsFailed++;
            $display("FAIL halt.resetClears: got %h expected %h", got, obsT'(0));
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        e = '0; e.memReq = 1'b1;
        pushCycle("halt.refetch", mkStim(1'b0, 16'h0000, 1'b0, 1'b0), e);
        queueInstr("afterHalt", 16'h5140, 1'b0, 1'b0, 0, 0, 0);
        drain(100);
    endtask

    initial begin
        test_reset();
        test_setlow();
        test_sethi();
        test_alu();
        test_load_wait();
        test_store();
        test_branch();
        test_illegal();
        test_back_to_back();
        test_reset_mid_mem();
        test_halt();
        if (expQ.size() != 0) begin
            testsRun++;
            testsFailed++;
            $display("FAIL scoreboard.leftover: got %0d entries expected 0", expQ.size());
        end
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/marc_control_unit.md
MARC_CONTROL_UNIT -- requirements
Module: marc_control_unit

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, all state updates on rising edge.
REQ-002 SHALL have: reset  in  1  asynchronous, active-low; low forces reset state immediately.
REQ-003 SHALL have: dataIn  in  16  instruction word from main memory, valid when mem_ready=1.
REQ-004 SHALL have: mem_ready  in  1  memory completes the current access this cycle.
REQ-005 SHALL have: z_flag, n_flag  in  1 each  ALU zero/negative flags from datapath.
REQ-006 SHALL have: mem_req  out  1  memory access request; rw  out  1  (1=write, 0=read); addr_sel  out  1  (0=PC, 1=busA).
REQ-007 SHALL have: pc_inc, pc_load  out  1 each  PC increment / PC<=PC+imm.
REQ-008 SHALL have: rf_we  out  1; rf_waddr, rf_raddr_a, rf_raddr_b  out  3 each  register-file control.
REQ-009 SHALL have: imm  out  16; alu_op  out  3; wb_sel  out  1  (0=ALU, 1=dataIn).
REQ-010 SHALL have: state  out  3  current state; halt  out  1; illegal  out  1.

Function
REQ-011 SHALL hold internal 16-bit IR; fields: op=IR[15:11], rd=IR[10:8], rs1=IR[7:5], rs2=IR[4:2], imm8=IR[7:0].
REQ-012 SHALL decode: 00000 add, 00001 sub, 00010 and, 00011 or (rd<=rs1 op rs2); 01010 setlow (rd<={8'h00,imm8}); 01011 sethi (rd<={imm8,rd[7:0]}); 10000 ld (rd<=mem[rs1]); 10001 st (mem[rs1]<=rs2); 11000 be (branch if z); 11001 bneg (branch if n); 11111 halt.
REQ-013 SHALL encode states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5; state output equals current state.
REQ-014 FETCH: mem_req=1, rw=0, addr_sel=0; stay while mem_ready=0; on mem_ready=1 capture dataIn into IR, pulse pc_inc one cycle, go DECODE.
REQ-015 DECODE: drive rf_raddr_a/b from IR (sethi: rf_raddr_a=rd); go EXEC; unknown opcode: pulse illegal one cycle, go FETCH (no-op).
REQ-016 EXEC: ALU/setlow/sethi -> WB; ld/st -> MEM; be/bneg -> pc_load=1 iff flag sampled this cycle is 1, then FETCH; halt -> HALT.
REQ-017 alu_op: add=000, sub=001, and=010, or=011, setlow=100, sethi=101, pass-A=110; held stable DECODE through WB.
REQ-018 imm SHALL be {8'h00,imm8} for setlow/sethi and sign-extended imm8 for branches, 0 otherwise.
REQ-019 MEM: mem_req=1, addr_sel=1, rw=1 for st, 0 for ld; wait on mem_ready=0; on mem_ready=1: st -> FETCH, ld -> WB.
REQ-020 WB: rf_we=1 for exactly one cycle, rf_waddr=rd, wb_sel=1 for ld else 0; then FETCH.
REQ-021 rw SHALL be 0 and mem_req 0 in every state except FETCH and MEM; rf_we SHALL be 0 outside WB.
REQ-022 Latency with zero wait (mem_ready=1): ALU/set 4 cycles, ld 5, st 4, branch 3, per instruction start-to-next-FETCH.
REQ-023 HALT: halt=1, all strobes 0, sticky until reset.
REQ-024 Writes to rd=0 SHALL still assert rf_we (register file decides %r0 semantics).
REQ-025 mem_ready asserted outside FETCH/MEM SHALL be ignored.

Reset
REQ-026 reset=0 SHALL asynchronously force state=FETCH, IR=16'h0000, and all outputs 0 except state (0).
REQ-027 reset asserted mid-MEM SHALL abort access: mem_req and rw drop in the same cycle; no rf_we pulse follows.
REQ-028 After reset rises, first rising clk edge SHALL evaluate FETCH with mem_req=1.

Verification
REQ-029 setlow: dataIn=16'h5140, mem_ready=1 -> DECODE, EXEC, WB with rf_waddr=1, alu_op=100, imm=16'h0040, rf_we one cycle.
REQ-030 sethi: dataIn=16'h5A01 -> rf_raddr_a=2, alu_op=101, imm=16'h0001, rf_waddr=2 in WB.
REQ-031 ld with mem_ready low 3 cycles in MEM -> state stays MEM 4 cycles, rw=0, addr_sel=1, then WB with wb_sel=1.
REQ-032 be imm8=8'hFE: z_flag=1 -> pc_load=1, imm=16'hFFFE; z_flag=0 -> pc_load=0; both return to FETCH.
REQ-033 dataIn=16'hF800 (halt) -> halt=1 held 10+ cycles ignoring mem_ready; reset low clears halt immediately.
REQ-034 opcode 00111 -> illegal pulse one cycle, no rf_we, no mem_req before next FETCH.
